// File: rtl/morty_hazard_ctrl.sv
// Pipeline hazard controller: per-cycle stall/bubble/flush/PC-select for the five-stage core,
// with a small FSM sequencing FENCE drain and trap flush, plus a wrapping stall-cycle counter.
module morty_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_fence_op,
  input  logic [4:0]  ex_waddr,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        imem_valid,
  input  logic        dmem_busy,
  input  logic        wb_trap_valid,
  input  logic        wb_xret_op,
  output logic        if_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_stall,
  output logic        idex_bubble,
  output logic        exmem_stall,
  output logic        exmem_bubble,
  output logic        memwb_bubble,
  output logic [1:0]  pc_sel,
  output logic        fence_flush,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FENCE = 2'b01,
    ST_TRAP  = 2'b10
  } state_e;

  localparam logic [3:0] CntLast = 4'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        fence_done_q, fence_done_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic        load_use;

  assign load_use = ex_mem_read && (ex_waddr != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_waddr)) ||
                     (id_use_rs2 && (id_rs2 == ex_waddr)));

  always_comb begin
    if_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_stall  = 1'b0;
    exmem_bubble = 1'b0;
    memwb_bubble = 1'b0;
    pc_sel       = 2'b00;
    fence_flush  = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;

    if (rst) begin
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      memwb_bubble = 1'b1;
    end else if (wb_trap_valid || wb_xret_op) begin
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      memwb_bubble = 1'b1;
      pc_sel       = 2'b10;
      state_d      = ST_TRAP;
      cnt_d        = 4'd0;
    end else if (state_q == ST_TRAP) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = ST_RUN;
    end else if (dmem_busy) begin
      if_stall     = 1'b1;
      ifid_stall   = 1'b1;
      idex_stall   = 1'b1;
      exmem_stall  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      pc_sel      = 2'b01;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (state_q == ST_FENCE) begin
      if_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
      if (cnt_q == CntLast) begin
        fence_flush = 1'b1;
        cnt_d       = 4'd0;
        state_d     = ST_RUN;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else if (load_use) begin
      if_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end else if (id_fence_op && !fence_done_q) begin
      if_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = ST_FENCE;
      cnt_d       = 4'd0;
    end else if (!imem_valid) begin
      if_stall   = 1'b1;
      ifid_flush = 1'b1;
    end
  end

  // The drained FENCE stays in ID one more cycle; this flag lets it issue instead of re-entering.
  always_comb begin
    fence_done_d = fence_done_q;
    if (fence_flush)
      fence_done_d = 1'b1;
    else if (!ifid_stall)
      fence_done_d = 1'b0;
  end

  assign stall_cycles_d = stall_cycles_q + {31'd0, if_stall};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      cnt_q          <= 4'd0;
      fence_done_q   <= 1'b0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      fence_done_q   <= fence_done_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign ctrl_state   = state_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_morty_hazard_ctrl.sv
// Directed bench for morty_hazard_ctrl: hand-computed control vectors, state and stall counts.
module tb_morty_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_waddr;
  logic        id_use_rs1, id_use_rs2, id_fence_op;
  logic        ex_mem_read, ex_branch_taken, imem_valid, dmem_busy;
  logic        wb_trap_valid, wb_xret_op;
  logic        if_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble;
  logic        exmem_stall, exmem_bubble, memwb_bubble, fence_flush;
  logic [1:0]  pc_sel, ctrl_state;
  logic [31:0] stall_cycles;

  int errs = 0;
  int checks = 0;

  // {if_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble,
  //  exmem_stall, exmem_bubble, memwb_bubble, pc_sel[1:0], fence_flush}
  localparam logic [10:0] C_IDLE  = 11'b00000000000;
  localparam logic [10:0] C_RST   = 11'b00101011000;
  localparam logic [10:0] C_TRAP  = 11'b00101011100;
  localparam logic [10:0] C_TRST  = 11'b00101000000;
  localparam logic [10:0] C_BUSY  = 11'b11010101000;
  localparam logic [10:0] C_BR    = 11'b00101000010;
  localparam logic [10:0] C_HOLD  = 11'b11001000000;
  localparam logic [10:0] C_FLAST = 11'b11001000001;
  localparam logic [10:0] C_IMISS = 11'b10100000000;

  logic [10:0] ctl;
  assign ctl = {if_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble,
                exmem_stall, exmem_bubble, memwb_bubble, pc_sel, fence_flush};

  always #5 clk = ~clk;

  morty_hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_fence_op(id_fence_op),
    .ex_waddr(ex_waddr), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .imem_valid(imem_valid), .dmem_busy(dmem_busy),
    .wb_trap_valid(wb_trap_valid), .wb_xret_op(wb_xret_op),
    .if_stall(if_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_bubble(idex_bubble),
    .exmem_stall(exmem_stall), .exmem_bubble(exmem_bubble),
    .memwb_bubble(memwb_bubble), .pc_sel(pc_sel),
    .fence_flush(fence_flush), .ctrl_state(ctrl_state),
    .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cyc(input string tag, input logic [10:0] exp_ctl, input logic [1:0] exp_st);
    #1;
    chk({tag, ".ctl"}, {21'd0, ctl}, {21'd0, exp_ctl});
    chk({tag, ".st"}, {30'd0, ctrl_state}, {30'd0, exp_st});
    tick();
  endtask

  initial begin
    rst = 1'b1;
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_waddr = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_fence_op = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; imem_valid = 1'b1;
    dmem_busy = 1'b0; wb_trap_valid = 1'b0; wb_xret_op = 1'b0;
    #3;
    chk("rst.ctl", {21'd0, ctl}, {21'd0, C_RST});
    chk("rst.st", {30'd0, ctrl_state}, 32'd0);
    chk("rst.cnt", stall_cycles, 32'd0);
    tick(); tick();
    rst = 1'b0;
    cyc("idle", C_IDLE, 2'b00);

    // load-use on rs1, then on rs2, then non-hazards
    ex_mem_read = 1'b1; ex_waddr = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    cyc("lu_rs1", C_HOLD, 2'b00);
    ex_mem_read = 1'b0;
    cyc("lu_after", C_IDLE, 2'b00);
    ex_mem_read = 1'b1; id_use_rs1 = 1'b0; id_rs1 = 5'd1; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    cyc("lu_rs2", C_HOLD, 2'b00);
    id_use_rs2 = 1'b0;
    cyc("lu_nouse", C_IDLE, 2'b00);
    ex_waddr = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    cyc("lu_x0", C_IDLE, 2'b00);
    ex_mem_read = 1'b0; id_use_rs1 = 1'b0;

    // branch blocked by dmem_busy, then resolves
    ex_branch_taken = 1'b1; dmem_busy = 1'b1;
    cyc("br_busy", C_BUSY, 2'b00);
    dmem_busy = 1'b0;
    cyc("br_go", C_BR, 2'b00);
    ex_branch_taken = 1'b0;
    cyc("br_after", C_IDLE, 2'b00);
    chk("cnt3", stall_cycles, 32'd3);

    // FENCE drain, no re-entry afterwards
    id_fence_op = 1'b1;
    cyc("f_entry", C_HOLD, 2'b00);
    cyc("f_c0", C_HOLD, 2'b01);
    cyc("f_c1", C_HOLD, 2'b01);
    cyc("f_c2", C_FLAST, 2'b01);
    cyc("f_norentry", C_IDLE, 2'b00);
    chk("cnt7", stall_cycles, 32'd7);

    // second FENCE interrupted by a trap in its 2nd drain cycle
    cyc("t_entry", C_HOLD, 2'b00);
    cyc("t_c0", C_HOLD, 2'b01);
    wb_trap_valid = 1'b1;
    cyc("t_trap", C_TRAP, 2'b01);
    wb_trap_valid = 1'b0; id_fence_op = 1'b0;
    cyc("t_trapst", C_TRST, 2'b10);
    cyc("t_run", C_IDLE, 2'b00);
    chk("cnt9", stall_cycles, 32'd9);

    // xRET from RUN
    wb_xret_op = 1'b1;
    cyc("x_ret", C_TRAP, 2'b00);
    wb_xret_op = 1'b0;
    cyc("x_trapst", C_TRST, 2'b10);

    // two-cycle fetch miss
    imem_valid = 1'b0;
    cyc("im0", C_IMISS, 2'b00);
    cyc("im1", C_IMISS, 2'b00);
    imem_valid = 1'b1;
    cyc("im_done", C_IDLE, 2'b00);
    chk("cnt11", stall_cycles, 32'd11);

    // asynchronous reset in the middle of a FENCE
    id_fence_op = 1'b1;
    cyc("r_entry", C_HOLD, 2'b00);
    #1;
    chk("r_infence", {30'd0, ctrl_state}, 32'd1);
    rst = 1'b1;
    #1;
    chk("r_async.st", {30'd0, ctrl_state}, 32'd0);
    chk("r_async.cnt", stall_cycles, 32'd0);
    chk("r_async.ctl", {21'd0, ctl}, {21'd0, C_RST});
    tick();
    chk("r_hold.ctl", {21'd0, ctl}, {21'd0, C_RST});
    chk("r_hold.cnt", stall_cycles, 32'd0);
    id_fence_op = 1'b0;
    rst = 1'b0;
    cyc("r_release", C_IDLE, 2'b00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
